// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor
// Sink-side checker for the 1280x800 VGA timing generator. Registers the
// hsync/vsync/video_on pins on the pixel clock, recovers the active-pixel
// coordinates, measures line/frame totals and active extents, and runs a
// lock FSM against the expected timing.
//
// Optional feature: define VGA_MON_STATS_EN to build the frame_count and
// err_count statistics counters. Without it both ports read constant 0.
`timescale 1ns/1ps

module vga_timing_monitor #(
    parameter int unsigned H_TOTAL_EXP  = 1440,
    parameter int unsigned V_TOTAL_EXP  = 831,
    parameter int unsigned H_ACTIVE_EXP = 1280,
    parameter int unsigned V_ACTIVE_EXP = 800,
    parameter int unsigned LOCK_FRAMES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        video_on,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        pixel_valid,
    output logic        frame_start,
    output logic [11:0] h_total_meas,
    output logic [10:0] v_total_meas,
    output logic [10:0] h_active_meas,
    output logic [9:0]  v_active_meas,
    output logic        locked,
    output logic        timing_err,
    output logic [15:0] frame_count,
    output logic [15:0] err_count
);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

    localparam logic [11:0] H_TOT   = 12'(H_TOTAL_EXP);
    localparam logic [10:0] H_ACT   = 11'(H_ACTIVE_EXP);
    localparam logic [10:0] V_TOT   = 11'(V_TOTAL_EXP);
    localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE_EXP);
    localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);
    localparam logic [11:0] H_MAX   = 12'hFFF;
    localparam logic [11:0] H_PRE   = 12'hFFE;
    localparam logic [10:0] HA_MAX  = 11'h7FF;
    localparam logic [10:0] V_MAX   = 11'h7FF;
    localparam logic [10:0] V_PRE   = 11'h7FE;
    localparam logic [9:0]  VA_MAX  = 10'h3FF;

    // input pipeline: current registered pin value and the one before it
    logic hs_r, vs_r, vo_r;
    logic hs_d, vs_d, vo_d;

    // coordinate recovery
    logic [10:0] x_cnt;
    logic [10:0] x_now;
    logic [9:0]  y_q;

    // line and frame measurement
    logic [11:0] h_cnt;
    logic [10:0] h_act_cnt;
    logic [10:0] v_cnt;
    logic [9:0]  v_act_cnt;
    logic        h_armed;
    logic        v_armed;
    logic        frame_bad;
    logic [11:0] h_total_q;
    logic [10:0] v_total_q;
    logic [10:0] h_active_q;
    logic [9:0]  v_active_q;

    // lock FSM
    state_t      state_q, state_n;
    logic [3:0]  good_q, good_n;
    logic        err_n;
    logic        timing_err_q;

    // derived events
    logic        hs_rise, vs_rise, vo_rise, vo_fall;
    logic        h_timeout, v_overflow, timeout;
    logic [10:0] v_cnt_inc;
    logic [9:0]  v_act_inc;
    logic        line_bad;
    logic        frame_good;

    assign hs_rise = hs_r & ~hs_d;
    assign vs_rise = vs_r & ~vs_d;
    assign vo_rise = vo_r & ~vo_d;
    assign vo_fall = ~vo_r & vo_d;

    // a line timeout fires once, on the clock the line counter would reach 4095
    assign h_timeout  = ~hs_rise && (h_cnt == H_PRE);
    assign v_overflow = hs_rise && (v_cnt == V_PRE);
    assign timeout    = h_timeout | v_overflow;

    // frame totals including any line or active line closing on this clock
    assign v_cnt_inc = (hs_rise && (v_cnt != V_MAX)) ? v_cnt + 11'd1 : v_cnt;
    assign v_act_inc = (vo_rise && (v_act_cnt != VA_MAX)) ? v_act_cnt + 10'd1 : v_act_cnt;

    assign line_bad = hs_rise && h_armed &&
                      ((h_cnt != H_TOT) || ((h_act_cnt != 11'd0) && (h_act_cnt != H_ACT)));

    assign frame_good = ~frame_bad && ~line_bad &&
                        (v_cnt_inc == V_TOT) && (v_act_inc == V_ACT);

    // x restarts at the first active clock of a run and holds while blanked
    always_comb begin
        x_now = x_cnt;
        if (vo_r) begin
            if (vo_d) begin
                x_now = x_cnt + 11'd1;
            end else begin
                x_now = 11'd0;
            end
        end
    end

    // register the sync/video pins once and keep the previous sample for edges
    always_ff @(posedge clk) begin
        if (!reset) begin
            hs_r <= 1'b0;
            vs_r <= 1'b0;
            vo_r <= 1'b0;
            hs_d <= 1'b0;
            vs_d <= 1'b0;
            vo_d <= 1'b0;
        end else begin
            hs_r <= hsync;
            vs_r <= vsync;
            vo_r <= video_on;
            hs_d <= hs_r;
            vs_d <= vs_r;
            vo_d <= vo_r;
        end
    end

    // track column and row; rows advance when an active run ends
    always_ff @(posedge clk) begin
        if (!reset) begin
            x_cnt <= 11'd0;
            y_q   <= 10'd0;
        end else begin
            x_cnt <= x_now;
            if (vs_rise) begin
                y_q <= 10'd0;
            end else if (vo_fall) begin
                y_q <= y_q + 10'd1;
            end
        end
    end

    // measure clocks and active clocks per line, closing each line on hsync rise
    always_ff @(posedge clk) begin
        if (!reset) begin
            h_cnt      <= 12'd0;
            h_act_cnt  <= 11'd0;
            h_armed    <= 1'b0;
            h_total_q  <= 12'd0;
            h_active_q <= 11'd0;
        end else begin
            if (hs_rise) begin
                h_cnt     <= 12'd1;
                h_act_cnt <= vo_r ? 11'd1 : 11'd0;
                h_armed   <= 1'b1;
                if (h_armed) begin
                    h_total_q <= h_cnt;
                    if (h_act_cnt != 11'd0) begin
                        h_active_q <= h_act_cnt;
                    end
                end
            end else begin
                if (h_cnt != H_MAX) begin
                    h_cnt <= h_cnt + 12'd1;
                end
                if (vo_r && (h_act_cnt != HA_MAX)) begin
                    h_act_cnt <= h_act_cnt + 11'd1;
                end
            end
            if (timeout) begin
                h_armed <= 1'b0;
            end
        end
    end

    // measure lines and active lines per frame, closing each frame on vsync rise
    always_ff @(posedge clk) begin
        if (!reset) begin
            v_cnt      <= 11'd0;
            v_act_cnt  <= 10'd0;
            v_armed    <= 1'b0;
            frame_bad  <= 1'b0;
            v_total_q  <= 11'd0;
            v_active_q <= 10'd0;
        end else begin
            if (vs_rise) begin
                v_cnt     <= 11'd0;
                v_act_cnt <= 10'd0;
                frame_bad <= 1'b0;
                v_armed   <= 1'b1;
                if (v_armed) begin
                    v_total_q  <= v_cnt_inc;
                    v_active_q <= v_act_inc;
                end
            end else begin
                v_cnt     <= v_cnt_inc;
                v_act_cnt <= v_act_inc;
                if (line_bad) begin
                    frame_bad <= 1'b1;
                end
            end
            if (timeout) begin
                v_armed   <= 1'b0;
                frame_bad <= 1'b0;
            end
        end
    end

    // lock FSM state, good-frame counter and the error pulse register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_UNLOCKED;
            good_q       <= 4'd0;
            timing_err_q <= 1'b0;
        end else begin
            state_q      <= state_n;
            good_q       <= good_n;
            timing_err_q <= err_n;
        end
    end

    // lock decisions: timeouts drop to UNLOCKED, frames are judged at vsync rise
    always_comb begin
        state_n = state_q;
        good_n  = good_q;
        err_n   = 1'b0;
        if (timeout) begin
            state_n = ST_UNLOCKED;
            good_n  = 4'd0;
            err_n   = 1'b1;
        end else if (vs_rise) begin
            case (state_q)
                ST_UNLOCKED: begin
                    state_n = ST_ACQUIRE;
                    good_n  = 4'd0;
                end
                ST_ACQUIRE: begin
                    if (frame_good) begin
                        if ((good_q + 4'd1) == LOCK_N) begin
                            state_n = ST_LOCKED;
                            good_n  = 4'd0;
                        end else begin
                            good_n = good_q + 4'd1;
                        end
                    end else begin
                        good_n = 4'd0;
                        err_n  = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!frame_good) begin
                        state_n = ST_ACQUIRE;
                        good_n  = 4'd0;
                        err_n   = 1'b1;
                    end
                end
                default: begin
                    state_n = ST_UNLOCKED;
                    good_n  = 4'd0;
                end
            endcase
        end
    end

`ifdef VGA_MON_STATS_EN
    logic [15:0] frame_count_q;
    logic [15:0] err_count_q;

    // count judged frames (wrapping) and error pulses (saturating)
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_count_q <= 16'd0;
            err_count_q   <= 16'd0;
        end else begin
            if (vs_rise && (state_q != ST_UNLOCKED)) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
            if (err_n && (err_count_q != 16'hFFFF)) begin
                err_count_q <= err_count_q + 16'd1;
            end
        end
    end

    assign frame_count = frame_count_q;
    assign err_count   = err_count_q;
`else
    assign frame_count = 16'd0;
    assign err_count   = 16'd0;
`endif

    assign x             = x_now;
    assign y             = y_q;
    assign pixel_valid   = vo_r;
    assign frame_start   = vs_rise;
    assign h_total_meas  = h_total_q;
    assign v_total_meas  = v_total_q;
    assign h_active_meas = h_active_q;
    assign v_active_meas = v_active_q;
    assign locked        = (state_q == ST_LOCKED);
    assign timing_err    = timing_err_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor
// Directed bench for vga_timing_monitor using a shrunken 20x10 raster
// (12x6 active) so whole frames fit in a few hundred clocks. The pixel
// generator lives in the bench; expected values are derived by hand from
// its fixed line/frame layout. Stats checks follow VGA_MON_STATS_EN.
`timescale 1ns/1ps

module tb_vga_timing_monitor;

    localparam int HT = 20;
    localparam int HA = 12;
    localparam int VT = 10;
    localparam int VA = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic [10:0] x;
    logic [9:0]  y;
    logic        pixel_valid;
    logic        frame_start;
    logic [11:0] h_total_meas;
    logic [10:0] v_total_meas;
    logic [10:0] h_active_meas;
    logic [9:0]  v_active_meas;
    logic        locked;
    logic        timing_err;
    logic [15:0] frame_count;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;
    int cyc;
    int hc, vc, fc;
    int hs0;
    int stretchFc;
    bit holdLow;
    int base;

    vga_timing_monitor #(
        .H_TOTAL_EXP (HT),
        .V_TOTAL_EXP (VT),
        .H_ACTIVE_EXP(HA),
        .V_ACTIVE_EXP(VA),
        .LOCK_FRAMES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .hsync        (hsync),
        .vsync        (vsync),
        .video_on     (video_on),
        .x            (x),
        .y            (y),
        .pixel_valid  (pixel_valid),
        .frame_start  (frame_start),
        .h_total_meas (h_total_meas),
        .v_total_meas (v_total_meas),
        .h_active_meas(h_active_meas),
        .v_active_meas(v_active_meas),
        .locked       (locked),
        .timing_err   (timing_err),
        .frame_count  (frame_count),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    // drive n pixel clocks from the raster generator, then sit 1ns past the edge
    task automatic applyStimulus(input int n);
        int lineLast;
        repeat (n) begin
            if (holdLow) begin
                hsync    = 1'b0;
                vsync    = 1'b0;
                video_on = 1'b0;
            end else begin
                video_on = (hc < HA) && (vc < VA);
                hsync    = (hc >= hs0) && (hc < hs0 + 2);
                vsync    = (vc == 7) || (vc == 8);
            end
            @(posedge clk);
            #1;
            cyc++;
            if (!holdLow) begin
                lineLast = ((fc == stretchFc) && (vc == 2)) ? HT : HT - 1;
                if (hc >= lineLast) begin
                    hc = 0;
                    if (vc == VT - 1) begin
                        vc = 0;
                        fc++;
                    end else begin
                        vc++;
                    end
                end else begin
                    hc++;
                end
            end
        end
    endtask

    task automatic runTo(input int target);
        applyStimulus(target - cyc);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // hold reset for two clocks with idle pins, then restart the raster at (0,0)
    task automatic startStream(input int hsStart);
        holdLow = 1'b1;
        reset   = 1'b0;
        applyStimulus(2);
        reset     = 1'b1;
        holdLow   = 1'b0;
        hs0       = hsStart;
        hc        = 0;
        vc        = 0;
        fc        = 0;
        stretchFc = -1;
        cyc       = -1;
    endtask

    task automatic checkAllZero(input string phase);
        checkOutput({phase, " x"},             32'(x),             0);
        checkOutput({phase, " y"},             32'(y),             0);
        checkOutput({phase, " pixel_valid"},   32'(pixel_valid),   0);
        checkOutput({phase, " frame_start"},   32'(frame_start),   0);
        checkOutput({phase, " h_total_meas"},  32'(h_total_meas),  0);
        checkOutput({phase, " v_total_meas"},  32'(v_total_meas),  0);
        checkOutput({phase, " h_active_meas"}, 32'(h_active_meas), 0);
        checkOutput({phase, " v_active_meas"}, 32'(v_active_meas), 0);
        checkOutput({phase, " locked"},        32'(locked),        0);
        checkOutput({phase, " timing_err"},    32'(timing_err),    0);
        checkOutput({phase, " frame_count"},   32'(frame_count),   0);
        checkOutput({phase, " err_count"},     32'(err_count),     0);
    endtask

    initial begin
        hsync = 1'b0;
        vsync = 1'b0;
        video_on = 1'b0;
        reset = 1'b0;
        cyc = -1;
        hc = 0; vc = 0; fc = 0; hs0 = 14; stretchFc = -1; holdLow = 1'b1;

        $display("[TB] reset state");
        startStream(14);
        checkAllZero("reset");
        stretchFc = 3;

        $display("[TB] nominal acquisition and coordinates");
        runTo(140);
        checkOutput("fs rise1",      32'(frame_start), 1);
        checkOutput("lock rise1",    32'(locked),      0);
        runTo(141);
        checkOutput("fs pulse end",  32'(frame_start), 0);
        runTo(400);
        checkOutput("x first px",    32'(x),           0);
        checkOutput("y first px",    32'(y),           0);
        checkOutput("pv first px",   32'(pixel_valid), 1);
        runTo(421);
        checkOutput("x (1,1)",       32'(x),           1);
        checkOutput("y (1,1)",       32'(y),           1);
        runTo(511);
        checkOutput("x last px",     32'(x),           11);
        checkOutput("y last px",     32'(y),           5);
        checkOutput("pv last px",    32'(pixel_valid), 1);
        runTo(512);
        checkOutput("pv blank",      32'(pixel_valid), 0);
        checkOutput("x hold blank",  32'(x),           11);
        runTo(540);
        checkOutput("lock rise3",    32'(locked),      0);
        checkOutput("fs rise3",      32'(frame_start), 1);
        runTo(541);
        checkOutput("lock after3",   32'(locked),        1);
        checkOutput("err nominal",   32'(timing_err),    0);
        checkOutput("h_total",       32'(h_total_meas),  20);
        checkOutput("v_total",       32'(v_total_meas),  10);
        checkOutput("h_active",      32'(h_active_meas), 12);
        checkOutput("v_active",      32'(v_active_meas), 6);

        $display("[TB] stretched line while locked");
        runTo(680);
        checkOutput("h_total long",  32'(h_total_meas), 21);
        checkOutput("lock long ln",  32'(locked),       1);
        runTo(741);
        checkOutput("err before vs", 32'(timing_err),   0);
        checkOutput("lock before vs",32'(locked),       1);
        runTo(742);
        checkOutput("err bad frame", 32'(timing_err),   1);
        checkOutput("unlock bad fr", 32'(locked),       0);
        runTo(743);
        checkOutput("err one pulse", 32'(timing_err),   0);
        runTo(1141);
        checkOutput("relock early",  32'(locked),       0);
        runTo(1142);
        checkOutput("relock",        32'(locked),       1);
        checkOutput("h_total relock",32'(h_total_meas), 20);

        $display("[TB] hsync held low");
        runTo(1200);
        holdLow = 1'b1;
        runTo(5289);
        checkOutput("err pre tmo",   32'(timing_err),   0);
        checkOutput("lock pre tmo",  32'(locked),       1);
        runTo(5290);
        checkOutput("err timeout",   32'(timing_err),   1);
        checkOutput("unlock tmo",    32'(locked),       0);
`ifdef VGA_MON_STATS_EN
        checkOutput("frame_count",   32'(frame_count),  5);
        checkOutput("err_count",     32'(err_count),    2);
`else
        checkOutput("frame_count",   32'(frame_count),  0);
        checkOutput("err_count",     32'(err_count),    0);
`endif
        runTo(5291);
        checkOutput("err tmo pulse", 32'(timing_err),   0);
        runTo(6200);
        checkOutput("err saturated", 32'(timing_err),   0);
        checkOutput("h_total hold",  32'(h_total_meas), 20);
        holdLow = 1'b0;
        base = 6201;

        $display("[TB] reacquire then mid-frame reset");
        runTo(base + 540);
        checkOutput("reacq early",   32'(locked),       0);
        runTo(base + 541);
        checkOutput("reacq lock",    32'(locked),       1);
        runTo(base + 649);
        reset = 1'b0;
        applyStimulus(1);
        reset = 1'b1;
        checkAllZero("midreset");
        runTo(base + 1140);
        checkOutput("rst lock early",32'(locked),        0);
        runTo(base + 1141);
        checkOutput("rst relock",    32'(locked),        1);
        checkOutput("rst v_total",   32'(v_total_meas),  10);
        checkOutput("rst v_active",  32'(v_active_meas), 6);
`ifdef VGA_MON_STATS_EN
        checkOutput("rst frame_cnt", 32'(frame_count),   2);
`else
        checkOutput("rst frame_cnt", 32'(frame_count),   0);
`endif
        checkOutput("rst err_cnt",   32'(err_count),     0);

        $display("[TB] hsync and vsync rising together");
        startStream(0);
        runTo(140);
        checkOutput("co fs",         32'(frame_start),   1);
        runTo(540);
        checkOutput("co lock early", 32'(locked),        0);
        runTo(541);
        checkOutput("co lock",       32'(locked),        1);
        checkOutput("co v_total",    32'(v_total_meas),  10);
        checkOutput("co h_total",    32'(h_total_meas),  20);
        checkOutput("co h_active",   32'(h_active_meas), 12);
        checkOutput("co v_active",   32'(v_active_meas), 6);
        checkOutput("co err",        32'(timing_err),    0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
